cr16_alu_arbiter: RTL

- Shares one cr16_alu instance between two requesters, e.g. the execute stage (port 0) and an address/immediate sequencer (port 1).
- Performs round-robin arbitration over level requests and latches the winner's opcode and operands.
- Drives the ALU's enable/opcode/operand inputs, waits out the ALU's one-cycle registered latency, then returns result and status to the winner with a one-cycle done pulse.

---
 rtl/cr16_alu_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cr16_alu_arbiter.sv
// Round-robin arbiter sharing one registered-latency cr16_alu between two requesters.
// Grants on one edge, holds enable for one cycle, captures the ALU result two edges later.
module cr16_alu_arbiter #(
  parameter int P_WIDTH = 16
) (
  input  logic               I_CLK,
  input  logic               I_NRESET,
  input  logic [1:0]         I_REQ,
  input  logic [3:0]         I_OPCODE0,
  input  logic [3:0]         I_OPCODE1,
  input  logic [P_WIDTH-1:0] I_A0,
  input  logic [P_WIDTH-1:0] I_B0,
  input  logic [P_WIDTH-1:0] I_A1,
  input  logic [P_WIDTH-1:0] I_B1,
  output logic [1:0]         O_GNT,
  output logic [1:0]         O_DONE,
  output logic [P_WIDTH-1:0] O_RESULT,
  output logic [4:0]         O_STATUS,
  output logic               O_BUSY,
  output logic               O_ALU_ENABLE,
  output logic [3:0]         O_ALU_OPCODE,
  output logic [P_WIDTH-1:0] O_ALU_A,
  output logic [P_WIDTH-1:0] O_ALU_B,
  input  logic [P_WIDTH-1:0] I_ALU_C,
  input  logic [4:0]         I_ALU_STATUS
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_ptr;     // index of the requester favoured on a tie
  logic               r_winner;
  logic [1:0]         r_gnt;
  logic [1:0]         r_done;
  logic [P_WIDTH-1:0] r_result;
  logic [4:0]         r_status;
  logic               r_busy;
  logic               r_alu_enable;
  logic [3:0]         r_alu_opcode;
  logic [P_WIDTH-1:0] r_alu_a;
  logic [P_WIDTH-1:0] r_alu_b;

  state_t             w_state_next;
  logic               w_ptr_next;
  logic               w_winner_next;
  logic [1:0]         w_gnt_next;
  logic [1:0]         w_done_next;
  logic [P_WIDTH-1:0] w_result_next;
  logic [4:0]         w_status_next;
  logic               w_alu_enable_next;
  logic [3:0]         w_alu_opcode_next;
  logic [P_WIDTH-1:0] w_alu_a_next;
  logic [P_WIDTH-1:0] w_alu_b_next;
  logic               w_pick;

  // A lone requester always wins; on a tie the pointer decides.
  always_comb begin
    case (I_REQ)
      2'b01:   w_pick = 1'b0;
      2'b10:   w_pick = 1'b1;
      default: w_pick = r_ptr;
    endcase
  end

  always_comb begin
    w_state_next      = r_state;
    w_ptr_next        = r_ptr;
    w_winner_next     = r_winner;
    w_gnt_next        = 2'b00;
    w_done_next       = 2'b00;
    w_result_next     = r_result;
    w_status_next     = r_status;
    w_alu_enable_next = 1'b0;
    w_alu_opcode_next = r_alu_opcode;
    w_alu_a_next      = r_alu_a;
    w_alu_b_next      = r_alu_b;
    case (r_state)
      S_IDLE: begin
        if (|I_REQ) begin
          w_state_next      = S_ISSUE;
          w_winner_next     = w_pick;
          w_ptr_next        = ~w_pick;
          w_gnt_next        = w_pick ? 2'b10 : 2'b01;
          w_alu_enable_next = 1'b1;
          w_alu_opcode_next = w_pick ? I_OPCODE1 : I_OPCODE0;
          w_alu_a_next      = w_pick ? I_A1 : I_A0;
          w_alu_b_next      = w_pick ? I_B1 : I_B0;
        end
      end
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT: begin
        w_state_next  = S_DONE;
        w_result_next = I_ALU_C;
        w_status_next = I_ALU_STATUS;
        w_done_next   = r_winner ? 2'b10 : 2'b01;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      r_state      <= S_IDLE;
      r_ptr        <= 1'b0;
      r_winner     <= 1'b0;
      r_gnt        <= '0;
      r_done       <= '0;
      r_result     <= '0;
      r_status     <= '0;
      r_busy       <= 1'b0;
      r_alu_enable <= 1'b0;
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_ptr        <= w_ptr_next;
      r_winner     <= w_winner_next;
      r_gnt        <= w_gnt_next;
      r_done       <= w_done_next;
      r_result     <= w_result_next;
      r_status     <= w_status_next;
      r_busy       <= (w_state_next != S_IDLE);
      r_alu_enable <= w_alu_enable_next;
      r_alu_opcode <= w_alu_opcode_next;
      r_alu_a      <= w_alu_a_next;
      r_alu_b      <= w_alu_b_next;
    end
  end

  assign O_GNT        = r_gnt;
  assign O_DONE       = r_done;
  assign O_RESULT     = r_result;
  assign O_STATUS     = r_status;
  assign O_BUSY       = r_busy;
  assign O_ALU_ENABLE = r_alu_enable;
  assign O_ALU_OPCODE = r_alu_opcode;
  assign O_ALU_A      = r_alu_a;
  assign O_ALU_B      = r_alu_b;

endmodule
